// File: rtl/pipelined_adder.sv
// pipelined_adder: carry-chained add/sub split into NB_STAGES slices, valid/ready.
// Optional saturating clamp and overflow_o when ADDER_SATURATE_EN is defined.
`timescale 1ns/1ps
module pipelined_adder #(
  parameter int DATASIZE  = 8,
  parameter int NB_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DATASIZE-1:0] a_i,
  input  logic [DATASIZE-1:0] b_i,
  input  logic                carryin_i,
  input  logic                sub_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [DATASIZE-1:0] result_o,
  output logic                carryout_o,
  output logic                valid_o,
`ifdef ADDER_SATURATE_EN
  output logic                overflow_o,
`endif
  input  logic                ready_i
);

  localparam int W = DATASIZE / NB_STAGES;
  localparam int L = NB_STAGES - 1;

  if (NB_STAGES < 1 || NB_STAGES > DATASIZE) begin : g_bad_depth
    $error("pipelined_adder: NB_STAGES must be in 1..DATASIZE");
  end
  if (NB_STAGES >= 1 && (DATASIZE % NB_STAGES) != 0) begin : g_bad_split
    $error("pipelined_adder: DATASIZE must be a multiple of NB_STAGES");
  end

  // stage registers: operands, partial result, chained carry, valid
  logic [DATASIZE-1:0] a_q   [NB_STAGES];
  logic [DATASIZE-1:0] bx_q  [NB_STAGES];
  logic [DATASIZE-1:0] res_q [NB_STAGES];
  logic                c_q   [NB_STAGES];
  logic                v_q   [NB_STAGES];

  // what each stage sees at its input
  logic [DATASIZE-1:0] a_c   [NB_STAGES];
  logic [DATASIZE-1:0] bx_c  [NB_STAGES];
  logic [DATASIZE-1:0] res_c [NB_STAGES];
  logic                c_c   [NB_STAGES];
  logic                v_c   [NB_STAGES];

  // slice sums and partial results to be registered
  logic [W:0]          sum   [NB_STAGES];
  logic [DATASIZE-1:0] res_n [NB_STAGES];
  logic [DATASIZE-1:0] fin_n;

  logic en;

  assign en       = !valid_o || ready_i;
  assign ready_o  = en;
  assign valid_o  = v_q[L];
  assign result_o = res_q[L];
  assign carryout_o = c_q[L];

  // stage 0 is fed from the ports, stage k from stage k-1 registers
  always_comb begin
    a_c[0]   = a_i;
    bx_c[0]  = sub_i ? ~b_i : b_i;
    res_c[0] = '0;
    c_c[0]   = carryin_i;
    v_c[0]   = valid_i;
    for (int k = 1; k < NB_STAGES; k++) begin
      a_c[k]   = a_q[k-1];
      bx_c[k]  = bx_q[k-1];
      res_c[k] = res_q[k-1];
      c_c[k]   = c_q[k-1];
      v_c[k]   = v_q[k-1];
    end
  end

  // each stage adds its own W-bit slice and merges it into the result
  always_comb begin
    for (int k = 0; k < NB_STAGES; k++) begin
      sum[k] = {1'b0, a_c[k][k*W +: W]}
             + {1'b0, bx_c[k][k*W +: W]}
             + {{W{1'b0}}, c_c[k]};
      res_n[k] = res_c[k];
      res_n[k][k*W +: W] = sum[k][W-1:0];
    end
  end

`ifdef ADDER_SATURATE_EN
  logic s_c [NB_STAGES];
  logic s_q [NB_STAGES];
  logic ovf_n;
  logic ovf_q;

  assign overflow_o = ovf_q;

  // subtract flag travels with its beat down to the last stage
  always_comb begin
    s_c[0] = sub_i;
    for (int k = 1; k < NB_STAGES; k++) begin
      s_c[k] = s_q[k-1];
    end
  end

  // clamp in the last stage: add carry -> all ones, sub borrow -> zero
  always_comb begin
    ovf_n = s_c[L] ? !sum[L][W] : sum[L][W];
    fin_n = res_n[L];
    if (ovf_n) begin
      fin_n = s_c[L] ? '0 : '1;
    end
  end

  // sub flag and overflow registers, advanced with the rest of the pipe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NB_STAGES; k++) begin
        s_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < NB_STAGES; k++) begin
        if (v_c[k]) begin
          s_q[k] <= s_c[k];
        end
      end
      if (v_c[L]) begin
        ovf_q <= ovf_n;
      end
    end
  end
`else
  // plain wrap-around result out of the last stage
  always_comb begin
    fin_n = res_n[L];
  end
`endif

  // pipeline registers: valid always advances on en, data only with a beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NB_STAGES; k++) begin
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
        res_q[k] <= '0;
        c_q[k]   <= 1'b0;
        v_q[k]   <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < NB_STAGES; k++) begin
        v_q[k] <= v_c[k];
        if (v_c[k]) begin
          a_q[k]   <= a_c[k];
          bx_q[k]  <= bx_c[k];
          c_q[k]   <= sum[k][W];
          res_q[k] <= (k == L) ? fin_n : res_n[k];
        end
      end
    end
  end

endmodule
